apb_protocol_checker: RTL

Synthesisable, passive APB protocol checker that taps one APB bus with up to NUM_SEL slave selects. It tracks the phase of every transfer with a small state machine and flags violations of the setup/access sequence, select encoding and signal stability. It accumulates sticky error flags, a saturating error count and a completed-transfer count. It is instantiated beside the APB fabric in RTL and in the UVM environment, with its outputs read by the scoreboard or status registers.

---
 rtl/apb_protocol_checker.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/apb_protocol_checker.sv
// Passive APB protocol checker: tracks setup/access phases and flags sequencing, select and stability violations.
// Define APB_CHK_TIMEOUT_EN to build the wait-state counter and timeout flag (err_code[6]).
module apb_protocol_checker #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int NUM_SEL        = 1,
  parameter int CNT_WIDTH      = 16,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                  PCLK,
  input  logic                  PRESETn,
  input  logic [NUM_SEL-1:0]    PSEL,
  input  logic                  PENABLE,
  input  logic                  PWRITE,
  input  logic [ADDR_WIDTH-1:0] PADDR,
  input  logic [DATA_WIDTH-1:0] PWDATA,
  input  logic                  PREADY,
  input  logic                  PSLVERR,
  input  logic                  clr,
  output logic                  err_valid,
  output logic [6:0]            err_code,
  output logic [6:0]            err_sticky,
  output logic [CNT_WIDTH-1:0]  err_count,
  output logic                  xfer_done,
  output logic                  xfer_slverr,
  output logic [CNT_WIDTH-1:0]  xfer_count
);

  if (NUM_SEL < 1 || NUM_SEL > 16 || TIMEOUT_CYCLES < 1) begin : g_param_check
    $error("apb_protocol_checker: illegal parameter value");
  end

  typedef enum logic {IDLE = 1'b0, ACCESS = 1'b1} state_t;

  state_t                state_q, state_d;
  logic [NUM_SEL-1:0]    sel_q, sel_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  write_q, write_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                  stab_q, stab_d;

  logic [6:0]            code;
  logic                  done, capture, acc, sel_any, mismatch;

  logic                  err_valid_q, xfer_done_q, xfer_slverr_q;
  logic [6:0]            err_code_q, err_sticky_q, err_sticky_d;
  logic [CNT_WIDTH-1:0]  err_count_q, err_count_d, xfer_count_q, xfer_count_d;

`ifdef APB_CHK_TIMEOUT_EN
  localparam int WaitW = $clog2(TIMEOUT_CYCLES + 1);
  logic [WaitW-1:0] wait_q, wait_d;
  logic             to_q, to_d;
`endif

  assign sel_any  = |PSEL;
  assign mismatch = (PSEL != sel_q) || (PADDR != addr_q) || (PWRITE != write_q) ||
                    (write_q && (PWDATA != wdata_q));

  always_comb begin
    state_d = state_q;
    code    = '0;
    done    = 1'b0;
    capture = 1'b0;
    acc     = 1'b0;

    code[0] = PENABLE && !sel_any;
    code[1] = |(PSEL & (PSEL - NUM_SEL'(1)));

    case (state_q)
      IDLE: begin
        if (sel_any) begin
          capture = 1'b1;
          state_d = ACCESS;
          // Setup sample with PENABLE already high is handled as the access cycle itself.
          if (PENABLE) begin
            code[2] = 1'b1;
            acc     = 1'b1;
          end
        end
      end
      ACCESS: begin
        if (!sel_any) begin
          code[4] = 1'b1;
          state_d = IDLE;
        end else if (!PENABLE) begin
          code[3] = 1'b1;
          capture = 1'b1;
        end else begin
          acc = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    sel_d   = capture ? PSEL    : sel_q;
    addr_d  = capture ? PADDR   : addr_q;
    write_d = capture ? PWRITE  : write_q;
    wdata_d = capture ? PWDATA  : wdata_q;
    stab_d  = capture ? 1'b0    : stab_q;

    if (acc) begin
      if (!capture && mismatch && !stab_q) begin
        code[5] = 1'b1;
        stab_d  = 1'b1;
      end
      if (PREADY) begin
        done    = 1'b1;
        state_d = IDLE;
      end
    end

`ifdef APB_CHK_TIMEOUT_EN
    wait_d = capture ? '0   : wait_q;
    to_d   = capture ? 1'b0 : to_q;
    if (acc && !PREADY) begin
      if (wait_d != WaitW'(TIMEOUT_CYCLES)) wait_d = wait_d + WaitW'(1);
      if ((wait_d == WaitW'(TIMEOUT_CYCLES)) && !to_d) begin
        code[6] = 1'b1;
        to_d    = 1'b1;
      end
    end
`endif

    // A new event in the same cycle as clr wins over the clear.
    err_sticky_d = (clr ? 7'd0 : err_sticky_q) | code;
    if (|code)
      err_count_d = clr ? CNT_WIDTH'(1) : ((&err_count_q) ? err_count_q : err_count_q + CNT_WIDTH'(1));
    else
      err_count_d = clr ? '0 : err_count_q;
    if (done)
      xfer_count_d = clr ? CNT_WIDTH'(1) : ((&xfer_count_q) ? xfer_count_q : xfer_count_q + CNT_WIDTH'(1));
    else
      xfer_count_d = clr ? '0 : xfer_count_q;
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q       <= IDLE;
      sel_q         <= '0;
      addr_q        <= '0;
      write_q       <= 1'b0;
      wdata_q       <= '0;
      stab_q        <= 1'b0;
      err_valid_q   <= 1'b0;
      err_code_q    <= '0;
      err_sticky_q  <= '0;
      err_count_q   <= '0;
      xfer_done_q   <= 1'b0;
      xfer_slverr_q <= 1'b0;
      xfer_count_q  <= '0;
    end else begin
      state_q       <= state_d;
      sel_q         <= sel_d;
      addr_q        <= addr_d;
      write_q       <= write_d;
      wdata_q       <= wdata_d;
      stab_q        <= stab_d;
      err_valid_q   <= |code;
      err_code_q    <= code;
      err_sticky_q  <= err_sticky_d;
      err_count_q   <= err_count_d;
      xfer_done_q   <= done;
      xfer_slverr_q <= done && PSLVERR;
      xfer_count_q  <= xfer_count_d;
    end
  end

`ifdef APB_CHK_TIMEOUT_EN
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      wait_q <= '0;
      to_q   <= 1'b0;
    end else begin
      wait_q <= wait_d;
      to_q   <= to_d;
    end
  end
`endif

  assign err_valid   = err_valid_q;
  assign err_code    = err_code_q;
  assign err_sticky  = err_sticky_q;
  assign err_count   = err_count_q;
  assign xfer_done   = xfer_done_q;
  assign xfer_slverr = xfer_slverr_q;
  assign xfer_count  = xfer_count_q;

endmodule
